mem_arbiter: RTL

Two-port arbiter and sequencer for the single shared system memory. It grants the memory port either to the processor core's load/store/fetch path (CPU) or to the external loader/debug port (EXT). It registers the winner's address, write-enable and write-data onto the memory, waits out a fixed read latency, and returns data with a one-cycle ready pulse. It sits between the top-level processor instance and the synchronous memory model; the CPU side stalls its multicycle controller until `o_cpu_ready`.

---
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter and sequencer. CPU and EXT share one synchronous
// memory. In IDLE the requests are sampled and arbitrated round-robin. The
// winner's address, write flag and write data are registered onto the memory
// port. ACCESS waits out the read latency, and RESP returns a one-cycle ready
// pulse to the granted port.
module mem_arbiter #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1     // memory read latency, legal range 1..7
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cpu_req,
  input  logic             i_cpu_we,
  input  logic [WIDTH-1:0] i_cpu_addr,
  input  logic [WIDTH-1:0] i_cpu_wdata,
  output logic [WIDTH-1:0] o_cpu_rdata,
  output logic             o_cpu_ready,
  input  logic             i_ext_req,
  input  logic             i_ext_we,
  input  logic [WIDTH-1:0] i_ext_addr,
  input  logic [WIDTH-1:0] i_ext_wdata,
  output logic [WIDTH-1:0] o_ext_rdata,
  output logic             o_ext_ready,
  output logic             o_mem_we,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0] o_mem_wdata,
  input  logic [WIDTH-1:0] i_mem_rdata,
  output logic [1:0]       o_grant,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [2:0] LAT       = 3'(LATENCY);
  localparam logic [1:0] GRANT_CPU = 2'b01;
  localparam logic [1:0] GRANT_EXT = 2'b10;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             last_ext_q, last_ext_d;   // 1: EXT was granted most recently
  logic             wr_q, wr_d;               // current transaction is a write
  logic [1:0]       grant_q, grant_d;
  logic             mem_we_q, mem_we_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [WIDTH-1:0] ext_rdata_q, ext_rdata_d;
  logic             cpu_ready_q, cpu_ready_d;
  logic             ext_ready_q, ext_ready_d;
  logic             any_req;
  logic             pick_ext;
  logic             access_done;

  // Arbitration and ACCESS completion: a lone requester wins; on a tie the
  // port that was not served last wins. A write needs one ACCESS cycle, a
  // read finishes once the counter reaches LATENCY.
  always_comb begin
    any_req     = i_cpu_req | i_ext_req;
    pick_ext    = i_ext_req & (~i_cpu_req | ~last_ext_q);
    access_done = wr_q | (cnt_q == LAT);
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values, independent of block order.
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (access_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the memory port, grant, counter and per-port responses.
  always_comb begin
    cnt_d       = cnt_q;
    last_ext_d  = last_ext_q;
    wr_d        = wr_q;
    grant_d     = grant_q;
    mem_we_d    = 1'b0;           // the strobe lives only in the first ACCESS cycle
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ext_rdata_d = ext_rdata_q;
    cpu_ready_d = 1'b0;
    ext_ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          cnt_d       = 3'd1;
          grant_d     = pick_ext ? GRANT_EXT : GRANT_CPU;
          wr_d        = pick_ext ? i_ext_we : i_cpu_we;
          mem_we_d    = pick_ext ? i_ext_we : i_cpu_we;
          mem_addr_d  = pick_ext ? i_ext_addr : i_cpu_addr;
          mem_wdata_d = pick_ext ? i_ext_wdata : i_cpu_wdata;
        end
      end
      ACCESS: begin
        if (access_done) begin
          if (!wr_q) begin
            if (grant_q[1]) ext_rdata_d = i_mem_rdata;
            else            cpu_rdata_d = i_mem_rdata;
          end
          cpu_ready_d = grant_q[0];
          ext_ready_d = grant_q[1];
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP: begin
        grant_d    = 2'b00;
        last_ext_d = grant_q[1];
      end
      default: ;
    endcase
  end

  // Datapath registers; reset aborts any transaction and drops the write strobe at once.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q       <= 3'd0;
      last_ext_q  <= 1'b1;
      wr_q        <= 1'b0;
      grant_q     <= 2'b00;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      ext_ready_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      last_ext_q  <= last_ext_d;
      wr_q        <= wr_d;
      grant_q     <= grant_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      ext_ready_q <= ext_ready_d;
    end
  end

  // FSM outputs.
  always_comb begin
    o_busy      = (state_q != IDLE);
    o_grant     = grant_q;
    o_mem_we    = mem_we_q;
    o_mem_addr  = mem_addr_q;
    o_mem_wdata = mem_wdata_q;
    o_cpu_rdata = cpu_rdata_q;
    o_cpu_ready = cpu_ready_q;
    o_ext_rdata = ext_rdata_q;
    o_ext_ready = ext_ready_q;
  end

endmodule
